aes_word_loader: RTL

Word-serial front end for the 128-bit AES core. It assembles 32-bit words into the 128-bit state and key registers that drive the core's inputs. It tracks the core's fixed pipeline latency and captures the ciphertext into a held result register with a valid/ready handshake. It sits directly upstream of the AES core, and its result port is the consumer side of the core's `out`. Only one block is in flight at a time.

---
 rtl/aes_io_pkg.sv | 11 +
 rtl/aes_word_shift.sv | 41 ++++
 rtl/aes_word_loader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/aes_io_pkg.sv
// Shared types and widths for the word-serial AES loader.
package aes_io_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int WORDS_PER_BLK = 4;
    localparam int WORD_W        = 32;
    localparam int BLK_W         = 128;
    localparam int LATENCY_DEF   = 21;

endpackage

// File: rtl/aes_word_shift.sv
// 128-bit big-endian word assembler: each load shifts left by one word and
// pulses wrap_o when the fourth word of a group is accepted.
module aes_word_shift
    import aes_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [BLK_W-1:0]  data_o,
    output logic              wrap_o
);

    localparam int CW = $clog2(WORDS_PER_BLK);

    logic [BLK_W-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (ld_en_i) begin
            data_d = {data_q[BLK_W-WORD_W-1:0], word_i};
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;
    assign wrap_o = ld_en_i & (cnt_q == CW'(WORDS_PER_BLK - 1));

endmodule

// File: rtl/aes_word_loader.sv
// Word-serial front end for the AES core: builds state/key, waits out the
// core latency and holds the ciphertext until the consumer takes it.
module aes_word_loader
    import aes_io_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_key,
    input  logic [WORD_W-1:0] ld_data,
    output logic [BLK_W-1:0]  core_state,
    output logic [BLK_W-1:0]  core_key,
    input  logic [BLK_W-1:0]  core_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [BLK_W-1:0]  res_data,
    output logic              busy,
    output logic [31:0]       blk_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             key_ok_q, key_ok_d;
    logic             pend_q, pend_d;
    logic             res_valid_q, res_valid_d;
    logic [BLK_W-1:0] res_data_q, res_data_d;
    logic [31:0]      blk_cnt_q;
    logic             st_ld, key_ld, st_wrap, key_wrap, hs;

    assign ld_ready = (state_q == IDLE);
    assign st_ld    = ld_valid & ld_ready & ~ld_key;
    assign key_ld   = ld_valid & ld_ready & ld_key;

    aes_word_shift u_state (
        .clk    (clk),
        .rst    (rst),
        .ld_en_i(st_ld),
        .word_i (ld_data),
        .data_o (core_state),
        .wrap_o (st_wrap)
    );

    aes_word_shift u_key (
        .clk    (clk),
        .rst    (rst),
        .ld_en_i(key_ld),
        .word_i (ld_data),
        .data_o (core_key),
        .wrap_o (key_wrap)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        key_ok_d    = key_ok_q | key_wrap;
        pend_d      = pend_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        hs          = 1'b0;
        case (state_q)
            IDLE: begin
                // A full state waiting on its first key issues when that key completes.
                if ((st_wrap & key_ok_q) | (key_wrap & pend_q)) begin
                    state_d = RUN;
                    lat_d   = '0;
                    pend_d  = 1'b0;
                end else if (st_wrap) begin
                    pend_d = 1'b1;
                end
            end
            RUN: begin
                lat_d = lat_q + CNT_W'(1);
                if (lat_q == CNT_W'(LATENCY - 1)) begin
                    res_data_d  = core_out;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_valid_q & res_ready) begin
                    hs          = 1'b1;
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            key_ok_q    <= 1'b0;
            pend_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            key_ok_q    <= key_ok_d;
            pend_q      <= pend_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else if (hs) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != IDLE);
    assign blk_cnt   = blk_cnt_q;

endmodule
